// File: rtl/rank_order_stream_if.sv
// Pixel-stream bundle for rank_order_stream: the input handshake plus the filtered output.
// The master side drives pixels. The slave side is the filter.
interface rank_order_stream_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 13
);
   logic              iValid;
   logic              oReady;
   logic [DATA_W-1:0] iPixel;
   logic [3:0]        iOrder;
   logic              iMode;
   logic              oValid;
   logic [DATA_W-1:0] oValue;
   logic [ADDR_W-1:0] oAddr;
   logic              oDone;

   modport master (output iValid, iPixel, iOrder, iMode,
                   input  oReady, oValid, oValue, oAddr, oDone);
   modport slave  (input  iValid, iPixel, iOrder, iMode,
                   output oReady, oValid, oValue, oAddr, oDone);
endinterface

// File: rtl/rank_order_stream.sv
// Streaming 3x3 rank-order filter. It uses two line buffers and a column history.
// Frame-border taps are masked from the output coordinates, followed by a 3-stage rank pipeline.
module rank_order_stream #(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 64,
   parameter int IMG_H  = 64,
   parameter int ADDR_W = 13
) (
   input logic iClk,
   input logic iRst,
   rank_order_stream_if.slave bus
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0]     COL_ZERO  = CW'(0);
   localparam logic [CW-1:0]     COL_LAST  = CW'(IMG_W - 1);
   localparam logic [RW-1:0]     ROW_ZERO  = RW'(0);
   localparam logic [RW-1:0]     ROW_ONE   = RW'(1);
   localparam logic [RW-1:0]     ROW_LAST  = RW'(IMG_H - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IMG_W * IMG_H - 1);

   typedef enum logic [1:0] {FILL = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;
   typedef logic [2:0][DATA_W-1:0] column_t;

   state_t            state_r, state_next_s;
   logic              ready_r, fire_s, step_s, emit_s, first_s;
   logic [CW-1:0]     in_col_r, out_col_r;
   logic [RW-1:0]     in_row_r, out_row_r;
   logic [ADDR_W-1:0] out_addr_r;
   logic [3:0]        order_r, order_eff_s;
   logic              mode_r;
   logic [DATA_W-1:0] lb0_r [IMG_W];
   logic [DATA_W-1:0] lb1_r [IMG_W];
   logic [DATA_W-1:0] pix_in_s;
   column_t           col_s, left_r, mid_r, lcol_s, ccol_s, rcol_s;
   logic [DATA_W-1:0] taps_s [9];
   logic [DATA_W-1:0] tap1_r [9];
   logic [DATA_W-1:0] tap2_r [9];
   logic [3:0]        cnt_s [9];
   logic [3:0]        cnt2_r [9];
   logic              vld1_r, vld2_r, done1_r, done2_r;
   logic [ADDR_W-1:0] addr1_r, addr2_r;
   logic [3:0]        ord1_r, ord2_r;
   logic [DATA_W-1:0] sel_s;
   logic              out_valid_r, out_done_r;
   logic [DATA_W-1:0] out_value_r;
   logic [ADDR_W-1:0] out_addr_q_r;

   // Row -1 and row IMG_H taps are replaced by the centre row, or by zero.
   function automatic column_t fix_rows(input column_t v, input logic top, input logic bot,
                                        input logic md);
      column_t f;
      f = v;
      if (top) f[0] = md ? v[1] : {DATA_W{1'b0}};
      else     f[0] = v[0];
      if (bot) f[2] = md ? v[1] : {DATA_W{1'b0}};
      else     f[2] = v[2];
      return f;
   endfunction

   assign bus.oReady = ready_r;
   assign bus.oValid = out_valid_r;
   assign bus.oValue = out_value_r;
   assign bus.oAddr  = out_addr_q_r;
   assign bus.oDone  = out_done_r;

   // State register; ready is registered from the next state
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_r <= FILL;
         ready_r <= 1'b1;
      end else begin
         state_r <= state_next_s;
         ready_r <= (state_next_s != FLUSH);
      end
   end

   // Next state and per-cycle step/emit strobes
   always_comb begin
      state_next_s = state_r;
      fire_s = 1'b0;
      step_s = 1'b0;
      emit_s = 1'b0;
      case (state_r)
         FILL: begin
            fire_s = bus.iValid & ready_r;
            step_s = fire_s;
            if (fire_s && in_row_r == ROW_ONE && in_col_r == COL_ZERO) state_next_s = RUN;
            else state_next_s = FILL;
         end
         RUN: begin
            fire_s = bus.iValid & ready_r;
            step_s = fire_s;
            emit_s = fire_s;
            if (fire_s && in_row_r == ROW_LAST && in_col_r == COL_LAST) state_next_s = FLUSH;
            else state_next_s = RUN;
         end
         FLUSH: begin
            step_s = 1'b1;
            emit_s = 1'b1;
            if (out_row_r == ROW_LAST && out_col_r == COL_LAST) state_next_s = FILL;
            else state_next_s = FLUSH;
         end
         default: state_next_s = FILL;
      endcase
   end

   // Rank select clamp and frame-start detect
   always_comb begin
      if (bus.iOrder == 4'd0)     order_eff_s = 4'd1;
      else if (bus.iOrder > 4'd9) order_eff_s = 4'd9;
      else                        order_eff_s = bus.iOrder;
      first_s  = fire_s && (state_r == FILL) && (in_row_r == ROW_ZERO) && (in_col_r == COL_ZERO);
      pix_in_s = (state_r == FLUSH) ? {DATA_W{1'b0}} : bus.iPixel;
   end

   // Input/output raster counters and per-frame rank/mode capture
   always_ff @(posedge iClk) begin
      if (iRst) begin
         in_col_r <= COL_ZERO;  in_row_r <= ROW_ZERO;
         out_col_r <= COL_ZERO; out_row_r <= ROW_ZERO;
         out_addr_r <= {ADDR_W{1'b0}};
         order_r <= 4'd1;
         mode_r <= 1'b0;
      end else begin
         if (state_r == FLUSH && state_next_s == FILL) begin
            in_col_r <= COL_ZERO;
            in_row_r <= ROW_ZERO;
         end else if (step_s) begin
            if (in_col_r == COL_LAST) begin
               in_col_r <= COL_ZERO;
               in_row_r <= (in_row_r == ROW_LAST) ? ROW_ZERO : in_row_r + ROW_ONE;
            end else begin
               in_col_r <= in_col_r + CW'(1);
            end
         end
         if (emit_s) begin
            out_addr_r <= (out_addr_r == ADDR_LAST) ? {ADDR_W{1'b0}} : out_addr_r + ADDR_W'(1);
            if (out_col_r == COL_LAST) begin
               out_col_r <= COL_ZERO;
               out_row_r <= (out_row_r == ROW_LAST) ? ROW_ZERO : out_row_r + ROW_ONE;
            end else begin
               out_col_r <= out_col_r + CW'(1);
            end
         end
         if (first_s) begin
            order_r <= order_eff_s;
            mode_r  <= bus.iMode;
         end
      end
   end

   // Line buffers: lb0 holds the previous row, lb1 the row before it (not reset)
   always_ff @(posedge iClk) begin
      if (step_s) begin
         lb1_r[in_col_r] <= lb0_r[in_col_r];
         lb0_r[in_col_r] <= pix_in_s;
      end
   end

   // Two-column history of the window; the third column arrives live
   always_ff @(posedge iClk) begin
      if (iRst) begin
         left_r <= '{default: {DATA_W{1'b0}}};
         mid_r  <= '{default: {DATA_W{1'b0}}};
      end else if (step_s) begin
         left_r <= mid_r;
         mid_r  <= col_s;
      end
   end

   // Window assembly. The right-edge output reuses the history with a padded right column.
   always_comb begin
      col_s[0] = lb1_r[in_col_r];
      col_s[1] = lb0_r[in_col_r];
      col_s[2] = pix_in_s;
      if (out_col_r == COL_ZERO) lcol_s = mode_r ? mid_r : '{default: {DATA_W{1'b0}}};
      else                       lcol_s = left_r;
      if (out_col_r == COL_LAST) rcol_s = mode_r ? mid_r : '{default: {DATA_W{1'b0}}};
      else                       rcol_s = col_s;
      lcol_s = fix_rows(lcol_s, out_row_r == ROW_ZERO, out_row_r == ROW_LAST, mode_r);
      ccol_s = fix_rows(mid_r,  out_row_r == ROW_ZERO, out_row_r == ROW_LAST, mode_r);
      rcol_s = fix_rows(rcol_s, out_row_r == ROW_ZERO, out_row_r == ROW_LAST, mode_r);
      for (int k = 0; k < 3; k++) begin
         taps_s[3*k]     = lcol_s[k];
         taps_s[3*k + 1] = ccol_s[k];
         taps_s[3*k + 2] = rcol_s[k];
      end
   end

   // Rank of each tap with index tie-break, so ranks are a permutation of 0..8
   always_comb begin
      for (int i = 0; i < 9; i++) begin
         cnt_s[i] = 4'd0;
         for (int j = 0; j < 9; j++) begin
            if ((tap1_r[j] < tap1_r[i]) || ((j < i) && (tap1_r[j] == tap1_r[i])))
               cnt_s[i] = cnt_s[i] + 4'd1;
            else
               cnt_s[i] = cnt_s[i];
         end
      end
      sel_s = {DATA_W{1'b0}};
      for (int i = 0; i < 9; i++) begin
         if (cnt2_r[i] == ord2_r - 4'd1) sel_s = tap2_r[i];
         else                            sel_s = sel_s;
      end
   end

   // Rank pipeline: S1 taps, S2 ranks, S3 selected output
   always_ff @(posedge iClk) begin
      if (iRst) begin
         vld1_r <= 1'b0; vld2_r <= 1'b0; done1_r <= 1'b0; done2_r <= 1'b0;
         addr1_r <= {ADDR_W{1'b0}}; addr2_r <= {ADDR_W{1'b0}};
         ord1_r <= 4'd1; ord2_r <= 4'd1;
         for (int i = 0; i < 9; i++) begin
            tap1_r[i] <= {DATA_W{1'b0}};
            tap2_r[i] <= {DATA_W{1'b0}};
            cnt2_r[i] <= 4'd0;
         end
         out_valid_r <= 1'b0; out_done_r <= 1'b0;
         out_value_r <= {DATA_W{1'b0}}; out_addr_q_r <= {ADDR_W{1'b0}};
      end else begin
         vld1_r  <= emit_s;
         done1_r <= emit_s && (out_addr_r == ADDR_LAST);
         if (emit_s) begin
            addr1_r <= out_addr_r;
            ord1_r  <= first_s ? order_eff_s : order_r;
            for (int i = 0; i < 9; i++) tap1_r[i] <= taps_s[i];
         end
         vld2_r  <= vld1_r;
         done2_r <= done1_r;
         if (vld1_r) begin
            addr2_r <= addr1_r;
            ord2_r  <= ord1_r;
            for (int i = 0; i < 9; i++) begin
               tap2_r[i] <= tap1_r[i];
               cnt2_r[i] <= cnt_s[i];
            end
         end
         out_valid_r <= vld2_r;
         out_done_r  <= done2_r;
         if (vld2_r) begin
            out_value_r  <= sel_s;
            out_addr_q_r <= addr2_r;
         end
      end
   end
endmodule

// File: tb/tb_rank_order_stream.sv
// Scoreboard bench for rank_order_stream on a 4x4 image.
// The driver queues hand-computed results per frame, and a negedge monitor pops and compares them.
module tb_rank_order_stream;
   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   int   done_cnt = 0;
   int   run_len  = 0;
   int   run_cnt  = 0;

   typedef struct {
      logic [7:0] v;
      logic [4:0] a;
      logic       d;
   } exp_t;
   exp_t sb_q[$];

   // Hand-computed 4x4 results, raster order
   logic [7:0] e_med  [16] = '{8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10,
                               8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10};
   logic [7:0] e_max  [16] = '{8'd255, 8'd255, 8'd255, 8'd10, 8'd255, 8'd255, 8'd255, 8'd10,
                               8'd255, 8'd255, 8'd255, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10};
   logic [7:0] e_zp   [16] = '{8'd0, 8'd10, 8'd10, 8'd0, 8'd10, 8'd10, 8'd10, 8'd10,
                               8'd10, 8'd10, 8'd10, 8'd10, 8'd0, 8'd10, 8'd10, 8'd0};
   logic [7:0] e_ramp [16] = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd0, 8'd0, 8'd1, 8'd2,
                               8'd4, 8'd4, 8'd5, 8'd6, 8'd8, 8'd8, 8'd9, 8'd10};

   rank_order_stream_if #(.DATA_W(8), .ADDR_W(5)) bus ();

   rank_order_stream #(.DATA_W(8), .IMG_W(4), .IMG_H(4), .ADDR_W(5)) dut (
      .iClk(clk),
      .iRst(rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Images: 0 = flat 10, 1 = flat 10 with 255 at index 5, 2 = ramp
   function automatic logic [7:0] pix_of(input int img, input int i);
      case (img)
         0:       return 8'd10;
         1:       return (i == 5) ? 8'd255 : 8'd10;
         default: return 8'(i);
      endcase
   endfunction

   function automatic logic [7:0] exp_of(input int tab, input int i);
      case (tab)
         0:       return e_med[i];
         1:       return e_max[i];
         2:       return e_zp[i];
         default: return e_ramp[i];
      endcase
   endfunction

   // Called at a negedge. It returns at a negedge once `count` pixels have transferred.
   task automatic send_frame(input int img, input int tab, input logic [3:0] ord,
                             input logic md, input bit gaps, input int count);
      int guard;
      if (count == 16) begin
         for (int i = 0; i < 16; i++) begin
            exp_t e;
            e.v = exp_of(tab, i);
            e.a = 5'(i);
            e.d = (i == 15);
            sb_q.push_back(e);
         end
      end
      for (int i = 0; i < count; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               bus.iValid = 1'b0;
               @(negedge clk);
            end
         end
         bus.iValid = 1'b1;
         bus.iPixel = pix_of(img, i);
         bus.iOrder = ord;
         bus.iMode  = md;
         guard = 0;
         while (!bus.oReady && guard < 50) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 50) chk("ready_timeout", guard, 0);
         @(negedge clk);
      end
      bus.iValid = 1'b0;
   endtask

   // Monitor: scoreboard compare, done qualification, flush ready-low length
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.oDone && !bus.oValid) chk("done_without_valid", 1, 0);
         if (bus.oValid) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_output_addr", int'(bus.oAddr), -1);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               chk("value", int'(bus.oValue), int'(e.v));
               chk("addr", int'(bus.oAddr), int'(e.a));
               chk("done", int'(bus.oDone), int'(e.d));
            end
            if (bus.oDone) done_cnt++;
         end
         if (!bus.oReady) begin
            run_len++;
         end else if (run_len != 0) begin
            chk("flush_ready_low_cycles", run_len, 5);
            run_cnt++;
            run_len = 0;
         end
      end
   end

   initial begin
      int guard;
      rst = 1'b1;
      bus.iValid = 1'b0;
      bus.iPixel = 8'd0;
      bus.iOrder = 4'd5;
      bus.iMode  = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_oValid", int'(bus.oValid), 0);
      chk("reset_oValue", int'(bus.oValue), 0);
      chk("reset_oAddr",  int'(bus.oAddr), 0);
      chk("reset_oDone",  int'(bus.oDone), 0);
      chk("reset_oReady", int'(bus.oReady), 1);
      rst = 1'b0;

      send_frame(1, 0, 4'd5,  1'b1, 1'b0, 16);
      send_frame(1, 1, 4'd9,  1'b1, 1'b0, 16);
      send_frame(0, 2, 4'd5,  1'b0, 1'b0, 16);
      send_frame(2, 3, 4'd1,  1'b1, 1'b0, 16);
      send_frame(2, 3, 4'd0,  1'b1, 1'b1, 16);
      send_frame(1, 1, 4'd12, 1'b1, 1'b1, 16);

      // Aborted frame: seven pixels, then reset; none of it may appear at the output
      send_frame(0, 2, 4'd9, 1'b0, 1'b0, 7);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("midreset_oValid", int'(bus.oValid), 0);
      chk("midreset_oReady", int'(bus.oReady), 1);

      send_frame(0, 2, 4'd5, 1'b0, 1'b0, 16);
      send_frame(1, 1, 4'd9, 1'b1, 1'b0, 16);

      guard = 0;
      while (sb_q.size() != 0 && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      repeat (10) @(negedge clk);
      chk("scoreboard_left", sb_q.size(), 0);
      chk("done_pulses", done_cnt, 8);
      chk("flush_windows", run_cnt, 8);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
